// File: rtl/path_product_combiner.sv
// rtl/path_product_combiner.sv - sums per-route products of segment path counts via a shift-add multiplier
// Optional feature macro: PATH_OVERFLOW_DETECT_EN (sticky overflow flag with saturating P/S).
module path_product_combiner #(
    parameter int COUNT_WIDTH  = 16,
    parameter int RESULT_WIDTH = 48,
    parameter int SEGMENTS     = 3,
    parameter int ROUTES       = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    restart,
    input  logic                    count_valid,
    output logic                    count_ready,
    input  logic [COUNT_WIDTH-1:0]  count_value,
    output logic                    result_valid,
    output logic [RESULT_WIDTH-1:0] result_value,
    output logic                    overflow
);

    localparam int PW  = RESULT_WIDTH + COUNT_WIDTH;
    localparam int BW  = (COUNT_WIDTH > 1) ? $clog2(COUNT_WIDTH) : 1;
    localparam int SW  = (SEGMENTS > 1) ? $clog2(SEGMENTS) : 1;
    localparam int RIW = (ROUTES > 1) ? $clog2(ROUTES) : 1;

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

    state_t                  state, state_nx;
    logic [RESULT_WIDTH-1:0] prod, sum;
    logic [COUNT_WIDTH-1:0]  mult;
    logic [PW-1:0]           partial, partial_nx, shifted;
    logic [BW-1:0]           bit_cnt;
    logic [SW-1:0]           seg_idx;
    logic [RIW-1:0]          route_idx;
    logic                    done_seen;
    logic                    last_bit, last_seg, last_route;
    logic [RESULT_WIDTH-1:0] prod_mul, sum_acc;

    assign last_bit   = (bit_cnt == BW'(COUNT_WIDTH - 1));
    assign last_seg   = (seg_idx == SW'(SEGMENTS - 1));
    assign last_route = (route_idx == RIW'(ROUTES - 1));

    // One multiplier bit per cycle; the multiplier register shifts so bit 0 is always current.
    always_comb begin
        shifted    = {{COUNT_WIDTH{1'b0}}, prod} << bit_cnt;
        partial_nx = mult[0] ? (partial + shifted) : partial;
    end

`ifdef PATH_OVERFLOW_DETECT_EN
    logic [RESULT_WIDTH:0] acc_sum;
    logic                  mul_ovf, acc_ovf, ovf;

    always_comb begin
        acc_sum  = {1'b0, sum} + {1'b0, prod};
        mul_ovf  = |partial_nx[PW-1:RESULT_WIDTH];
        acc_ovf  = acc_sum[RESULT_WIDTH];
        prod_mul = mul_ovf ? {RESULT_WIDTH{1'b1}} : partial_nx[RESULT_WIDTH-1:0];
        sum_acc  = acc_ovf ? {RESULT_WIDTH{1'b1}} : acc_sum[RESULT_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (restart) begin
            ovf <= 1'b0;
        end else if ((state == MUL && last_bit && mul_ovf) || (state == ACC && acc_ovf)) begin
            ovf <= 1'b1;
        end
    end

    assign overflow = ovf;
`else
    always_comb begin
        prod_mul = partial_nx[RESULT_WIDTH-1:0];
        sum_acc  = sum + prod;
    end

    assign overflow = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (count_valid) state_nx = MUL;
            MUL:  if (last_bit) state_nx = last_seg ? ACC : IDLE;
            ACC:  state_nx = last_route ? DONE : IDLE;
            DONE: state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    assign count_ready  = (state == IDLE);
    assign result_valid = (state == DONE) && !done_seen;
    assign result_value = (state == DONE) ? sum : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prod      <= RESULT_WIDTH'(1);
            sum       <= '0;
            mult      <= '0;
            partial   <= '0;
            bit_cnt   <= '0;
            seg_idx   <= '0;
            route_idx <= '0;
            done_seen <= 1'b0;
        end else if (restart) begin
            state     <= IDLE;
            prod      <= RESULT_WIDTH'(1);
            sum       <= '0;
            mult      <= '0;
            partial   <= '0;
            bit_cnt   <= '0;
            seg_idx   <= '0;
            route_idx <= '0;
            done_seen <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (count_valid) begin
                        mult    <= count_value;
                        partial <= '0;
                        bit_cnt <= '0;
                    end
                end
                MUL: begin
                    partial <= partial_nx;
                    mult    <= mult >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (last_bit) begin
                        prod <= prod_mul;
                        if (!last_seg) seg_idx <= seg_idx + 1'b1;
                    end
                end
                ACC: begin
                    sum     <= sum_acc;
                    prod    <= RESULT_WIDTH'(1);
                    seg_idx <= '0;
                    if (!last_route) route_idx <= route_idx + 1'b1;
                end
                DONE: done_seen <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_path_product_combiner.sv
// tb/tb_path_product_combiner.sv - self-checking bench for path_product_combiner
module tb_path_product_combiner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        restart = 1'b0;
    logic        count_valid = 1'b0;
    logic [15:0] count_value = '0;
    logic        count_ready;
    logic        result_valid;
    logic [47:0] result_value;
    logic        overflow;

    path_product_combiner dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .restart      (restart),
        .count_valid  (count_valid),
        .count_ready  (count_ready),
        .count_value  (count_value),
        .result_valid (result_valid),
        .result_value (result_value),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef logic [5:0][15:0] stream_t;
    typedef struct {
        stream_t     c;
        logic [47:0] exp_r;
        logic        exp_ov;
    } vec_t;

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          pulses = 0;
    int          t_res = 0;
    logic [15:0] acc_q[$];
    vec_t        vecs[4];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && !restart && count_valid && count_ready) acc_q.push_back(count_value);
    end

    always @(negedge clk) begin
        if (result_valid) begin
            pulses = pulses + 1;
            t_res  = cyc;
        end
    end

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic stream_t mk(input logic [15:0] a, b, c, d, e, f);
        stream_t r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e; r[5] = f;
        return r;
    endfunction

    // Reference: plain integer products per route, summed, with wrap or saturation.
    function automatic void model(input stream_t c, output logic [47:0] r, output logic ov);
        longint unsigned lim, p, s, full;
        lim = 64'h0000_FFFF_FFFF_FFFF;
        s   = 0;
        ov  = 1'b0;
        for (int rt = 0; rt < 2; rt++) begin
            p = 1;
            for (int sg = 0; sg < 3; sg++) begin
                full = p * longint'(c[rt*3+sg]);
`ifdef PATH_OVERFLOW_DETECT_EN
                if (full > lim) begin p = lim; ov = 1'b1; end
                else p = full;
`else
                p = full & lim;
`endif
            end
            s = s + p;
`ifdef PATH_OVERFLOW_DETECT_EN
            if (s > lim) begin s = lim; ov = 1'b1; end
`else
            s = s & lim;
`endif
        end
        r = s[47:0];
    endfunction

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic send_one(input logic [15:0] v, input int gap, output int t);
        int n;
        if (gap > 0) begin
            count_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        count_valid = 1'b1;
        count_value = v;
        n = 0;
        while (!count_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!count_ready) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        t = cyc;
    endtask

    task automatic run_stream(input stream_t c, input int gap_max, input logic [47:0] exp_r,
                              input logic exp_ov, input string tag, input bit chk_lat);
        int base_p, base_a, t0, t, n;
        bit ok;
        base_p = pulses;
        base_a = acc_q.size();
        t0 = 0;
        for (int i = 0; i < 6; i++) begin
            send_one(c[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0, t);
            if (i == 0) t0 = t;
        end
        count_valid = 1'b0;
        n = 0;
        while (pulses == base_p && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_result_seen"}, (pulses != base_p) ? 1 : 0, 1);
        repeat (4) @(negedge clk);
        check({tag, "_pulse_count"}, pulses - base_p, 1);
        check({tag, "_value"}, result_value, exp_r);
        check({tag, "_overflow"}, overflow, exp_ov);
        check({tag, "_valid_low"}, result_valid, 0);
        if (chk_lat) check({tag, "_latency"}, t_res - t0 + 1, 104);
        ok = (acc_q.size() - base_a == 6);
        for (int i = 0; i < 6 && ok; i++) if (acc_q[base_a+i] != c[i]) ok = 1'b0;
        check({tag, "_accept_order"}, ok, 1);
    endtask

    initial begin
        stream_t     rs;
        logic [47:0] mr;
        logic        mo;
        int          gm, tt;

        vecs[0] = '{c: mk(2, 3, 4, 5, 6, 7), exp_r: 48'd234, exp_ov: 1'b0};
        vecs[1] = '{c: mk(0, 16'hFFFF, 16'hFFFF, 1, 1, 1), exp_r: 48'd1, exp_ov: 1'b0};
`ifdef PATH_OVERFLOW_DETECT_EN
        vecs[2] = '{c: mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF),
                    exp_r: 48'hFFFF_FFFF_FFFF, exp_ov: 1'b1};
`else
        vecs[2] = '{c: mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF),
                    exp_r: 48'hFFFA_0005_FFFE, exp_ov: 1'b0};
`endif
        vecs[3] = '{c: mk(1, 2, 3, 4, 5, 6), exp_r: 48'd126, exp_ov: 1'b0};

        repeat (3) @(negedge clk);
        check("reset_ready", count_ready, 1);
        check("reset_valid", result_valid, 0);
        check("reset_value", result_value, 0);
        check("reset_overflow", overflow, 0);
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            do_restart();
            run_stream(vecs[v].c, 0, vecs[v].exp_r, vecs[v].exp_ov, $sformatf("vec%0d", v), 1'b1);
        end

        // Restart from DONE must hide the old result before the new stream runs.
        do_restart();
        check("restart_value", result_value, 0);
        check("restart_valid", result_valid, 0);
        check("restart_ready", count_ready, 1);
        check("restart_overflow", overflow, 0);
        run_stream(mk(10, 10, 10, 0, 0, 0), 0, 48'd1000, 1'b0, "after_restart", 1'b1);

        // Asynchronous reset in the 5th MUL cycle of route 1, segment 0.
        do_restart();
        send_one(16'd1, 0, tt);
        send_one(16'd2, 0, tt);
        send_one(16'd3, 0, tt);
        send_one(16'd4, 0, tt);
        count_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midmul_rst_ready", count_ready, 1);
        check("midmul_rst_valid", result_valid, 0);
        check("midmul_rst_value", result_value, 0);
        check("midmul_rst_overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_stream(mk(1, 1, 1, 1, 1, 2), 0, 48'd3, 1'b0, "post_reset", 1'b1);

        for (int k = 0; k < 15; k++) begin
            for (int i = 0; i < 6; i++) begin
                case ($urandom_range(0, 3))
                    0: rs[i] = 16'd0;
                    1: rs[i] = 16'hFFFF;
                    2: rs[i] = 16'($urandom_range(0, 15));
                    default: rs[i] = 16'($urandom);
                endcase
            end
            model(rs, mr, mo);
            gm = ($urandom_range(0, 1) == 1) ? 3 : 0;
            do_restart();
            run_stream(rs, gm, mr, mo, $sformatf("rand%0d", k), gm == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
